// File: rtl/echo_range_meter_pkg.sv
// Shared constants, FSM state codes and small helpers for the ultrasonic echo range meter.
// Imported by the interface, the divider and the top level.
package echo_range_meter_pkg;

    localparam int unsigned TIMEOUT_US_DEF = 32'd30000;
    localparam int unsigned CM_DIV_DEF     = 32'd58;
    localparam int unsigned WIDTH_W_DEF    = 32'd16;
    localparam int unsigned DIST_W_DEF     = 32'd10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_MEASURE  = 3'd2,
        ST_WAIT_LOW = 3'd3,
        ST_DIVIDE   = 3'd4
    } state_e;

    // High for one cycle when cur is set and prev (its one-cycle-old copy) is clear.
    function automatic logic f_rise(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/echo_range_meter_if.sv
// Trigger/echo inputs and distance/strobe outputs of the range meter, named from the meter's side.
// slave = the meter, master = whoever drives trig/echo and consumes the result.
interface echo_range_meter_if #(
    parameter int unsigned DIST_W = 32'd10
);
    logic              i_trig;
    logic              i_echo;
    logic [DIST_W-1:0] o_dist_cm;
    logic              o_dist_valid;
    logic              o_timeout;
    logic              o_busy;

    modport master (
        output i_trig,
        output i_echo,
        input  o_dist_cm,
        input  o_dist_valid,
        input  o_timeout,
        input  o_busy
    );

    modport slave (
        input  i_trig,
        input  i_echo,
        output o_dist_cm,
        output o_dist_valid,
        output o_timeout,
        output o_busy
    );
endinterface

// File: rtl/echo_range_meter_seq_divider.sv
// Restoring shift/subtract divider: one quotient bit per clock, done pulses WIDTH_W cycles after start.
// A start while a division is running restarts it with the new operands.
module seq_divider #(
    parameter int unsigned WIDTH_W = 32'd16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH_W-1:0] dividend,
    input  logic [WIDTH_W-1:0] divisor,
    output logic [WIDTH_W-1:0] quotient,
    output logic               done
);
    localparam int unsigned BITS_W = $clog2(WIDTH_W + 32'd1);
    localparam logic [BITS_W-1:0] C_BITS = BITS_W'(WIDTH_W);
    localparam logic [BITS_W-1:0] C_ONE  = BITS_W'(1);

    logic [WIDTH_W-1:0] r_rem;
    logic [WIDTH_W-1:0] r_quo;
    logic [BITS_W-1:0]  r_bits;
    logic               r_active;
    logic               r_done;

    logic [WIDTH_W:0]   w_shift;
    logic [WIDTH_W:0]   w_diff;
    logic               w_ge;
    logic               w_unused_diff_msb;

    // Trial subtraction of the divisor from the remainder with the next dividend bit shifted in.
    always_comb begin
        w_shift           = {r_rem, r_quo[WIDTH_W-1]};
        w_diff            = w_shift - {1'b0, divisor};
        w_ge              = (w_shift >= {1'b0, divisor});
        w_unused_diff_msb = w_diff[WIDTH_W];
    end

    // Dividend is shifted out of r_quo from the top while quotient bits enter at the bottom.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_bits   <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_rem    <= '0;
                r_quo    <= dividend;
                r_bits   <= C_BITS;
                r_active <= 1'b1;
            end else if (r_active) begin
                r_rem  <= w_ge ? w_diff[WIDTH_W-1:0] : w_shift[WIDTH_W-1:0];
                r_quo  <= {r_quo[WIDTH_W-2:0], w_ge};
                r_bits <= r_bits - C_ONE;
                if (r_bits == C_ONE) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign quotient = r_quo;
    assign done     = r_done;

endmodule

// File: rtl/echo_range_meter.sv
// Times the sensor echo after each trigger falling edge and reports distance in cm (width / CM_DIV),
// or a timeout strobe when the echo never rises or stays high too long.
module echo_range_meter
    import echo_range_meter_pkg::*;
#(
    parameter int unsigned TIMEOUT_US = TIMEOUT_US_DEF,
    parameter int unsigned CM_DIV     = CM_DIV_DEF,
    parameter int unsigned WIDTH_W    = WIDTH_W_DEF,
    parameter int unsigned DIST_W     = DIST_W_DEF
) (
    input  logic              clk_1m,
    input  logic              rst,
    echo_range_meter_if.slave bus
);
    localparam logic [WIDTH_W-1:0] C_TIMEOUT = WIDTH_W'(TIMEOUT_US);
    localparam logic [WIDTH_W-1:0] C_CM_DIV  = WIDTH_W'(CM_DIV);
    localparam logic [WIDTH_W-1:0] C_ONE     = WIDTH_W'(1);

    logic               r_echo_meta;
    logic               r_echo_sync;
    logic               r_echo_d;
    logic               r_trig_d;
    state_e             r_state;
    logic [WIDTH_W-1:0] r_cnt;
    logic [DIST_W-1:0]  r_dist_cm;
    logic               r_dist_valid;
    logic               r_timeout;

    state_e             w_state_nxt;
    logic [WIDTH_W-1:0] w_cnt_nxt;
    logic [WIDTH_W-1:0] w_cnt_inc;
    logic [DIST_W-1:0]  w_dist_nxt;
    logic               w_valid_nxt;
    logic               w_timeout_nxt;
    logic               w_div_start;
    logic               w_div_done;
    logic [WIDTH_W-1:0] w_quotient;
    logic               w_rise;
    logic               w_fall;
    logic               w_arm;
    logic               w_unused_quo_hi;

    // Echo synchronizer plus the one-cycle-old copies used for edge detection.
    always_ff @(posedge clk_1m or negedge rst) begin
        if (!rst) begin
            r_echo_meta <= 1'b0;
            r_echo_sync <= 1'b0;
            r_echo_d    <= 1'b0;
            r_trig_d    <= 1'b0;
        end else begin
            r_echo_meta <= bus.i_echo;
            r_echo_sync <= r_echo_meta;
            r_echo_d    <= r_echo_sync;
            r_trig_d    <= bus.i_trig;
        end
    end

    assign w_rise          = f_rise(r_echo_sync, r_echo_d);
    assign w_fall          = f_rise(r_echo_d, r_echo_sync);
    assign w_arm           = f_rise(r_trig_d, bus.i_trig);
    assign w_cnt_inc       = r_cnt + C_ONE;
    assign w_unused_quo_hi = ^w_quotient[WIDTH_W-1:DIST_W];

    // Next-state, counter and strobe decisions for the measurement FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_dist_nxt    = r_dist_cm;
        w_valid_nxt   = 1'b0;
        w_timeout_nxt = 1'b0;
        w_div_start   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arm) begin
                    w_state_nxt = ST_ARMED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ARMED: begin
                // Fire as the count reaches TIMEOUT_US so ARMED lasts exactly TIMEOUT_US cycles.
                if (w_rise) begin
                    w_state_nxt = ST_MEASURE;
                    w_cnt_nxt   = C_ONE;
                end else if (w_cnt_inc == C_TIMEOUT) begin
                    w_state_nxt   = ST_IDLE;
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_MEASURE: begin
                if (w_fall) begin
                    w_state_nxt = ST_DIVIDE;
                    w_div_start = 1'b1;
                end else if (r_cnt == C_TIMEOUT) begin
                    w_state_nxt   = ST_WAIT_LOW;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_WAIT_LOW: begin
                if (!r_echo_sync) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT_LOW;
                end
            end
            ST_DIVIDE: begin
                if (w_div_done) begin
                    w_state_nxt = ST_IDLE;
                    w_dist_nxt  = w_quotient[DIST_W-1:0];
                    w_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_DIVIDE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FSM state, width counter and registered result/strobe outputs.
    always_ff @(posedge clk_1m or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_dist_cm    <= '0;
            r_dist_valid <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_dist_cm    <= w_dist_nxt;
            r_dist_valid <= w_valid_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    seq_divider #(
        .WIDTH_W (WIDTH_W)
    ) u_div (
        .clk      (clk_1m),
        .rst      (rst),
        .start    (w_div_start),
        .dividend (r_cnt),
        .divisor  (C_CM_DIV),
        .quotient (w_quotient),
        .done     (w_div_done)
    );

    assign bus.o_dist_cm    = r_dist_cm;
    assign bus.o_dist_valid = r_dist_valid;
    assign bus.o_timeout    = r_timeout;
    assign bus.o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_echo_range_meter.sv
// Directed bench for echo_range_meter: hand-computed distances, strobe timing and timeout cases.
// Runs the DUT with a shortened TIMEOUT_US to keep the simulation short.
module tb_echo_range_meter;

    localparam int TMO = 8000;
    // echo drop -> 2 sync edges, 1 edge into DIVIDE, 16 divide edges, 1 strobe edge, +1 negedge index
    localparam int LAT_VALID = 21;

    logic clk_1m = 1'b0;
    logic rst    = 1'b0;

    echo_range_meter_if #(.DIST_W(10)) bus ();

    echo_range_meter #(
        .TIMEOUT_US (TMO),
        .CM_DIV     (58),
        .WIDTH_W    (16),
        .DIST_W     (10)
    ) dut (
        .clk_1m (clk_1m),
        .rst    (rst),
        .bus    (bus)
    );

    always #500 clk_1m = ~clk_1m;

    int n_checks = 0;
    int n_pass   = 0;

    int cyc = 0;
    int n_valid = 0;
    int n_to = 0;
    int last_valid_cyc = 0;
    int last_to_cyc = 0;
    int busy_rise_cyc = 0;
    int overlap = 0;
    int long_strobe = 0;
    logic prev_busy = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_to = 1'b0;

    // Strobe monitor sampling on the falling edge, away from the DUT's active edge.
    always @(negedge clk_1m) begin
        cyc        <= cyc + 1;
        prev_busy  <= bus.o_busy;
        prev_valid <= bus.o_dist_valid;
        prev_to    <= bus.o_timeout;
        if (bus.o_dist_valid) begin
            n_valid        <= n_valid + 1;
            last_valid_cyc <= cyc + 1;
        end
        if (bus.o_timeout) begin
            n_to        <= n_to + 1;
            last_to_cyc <= cyc + 1;
        end
        if (bus.o_busy && !prev_busy) busy_rise_cyc <= cyc + 1;
        if (bus.o_dist_valid && bus.o_timeout) overlap <= overlap + 1;
        if ((bus.o_dist_valid && prev_valid) || (bus.o_timeout && prev_to)) long_strobe <= long_strobe + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_1m);
        #1;
    endtask

    task automatic do_trig();
        bus.i_trig = 1'b1;
        step(10);
        bus.i_trig = 1'b0;
    endtask

    task automatic measure(input string tag, input int width, input int exp_cm);
        int v0;
        int fall_cyc;
        v0 = n_valid;
        do_trig();
        step(200);
        bus.i_echo = 1'b1;
        step(width);
        bus.i_echo = 1'b0;
        fall_cyc = cyc;
        for (int i = 0; i < 100 && n_valid == v0; i++) step(1);
        step(5);
        chk({tag, "_nvalid"}, n_valid - v0, 1);
        chk({tag, "_dist"}, int'(bus.o_dist_cm), exp_cm);
        chk({tag, "_latency"}, last_valid_cyc - fall_cyc, LAT_VALID);
        chk({tag, "_busy"}, int'(bus.o_busy), 0);
    endtask

    initial begin
        int v0;
        int t0;
        int f0;
        bus.i_trig = 1'b0;
        bus.i_echo = 1'b0;
        step(3);
        chk("rst_dist", int'(bus.o_dist_cm), 0);
        chk("rst_valid", int'(bus.o_dist_valid), 0);
        chk("rst_timeout", int'(bus.o_timeout), 0);
        chk("rst_busy", int'(bus.o_busy), 0);
        rst = 1'b1;
        step(3);

        measure("m580", 580, 10);
        measure("m5800", 5800, 100);

        // trigger with no echo: timeout TMO cycles after ARMED entry, distance kept
        v0 = n_valid; t0 = n_to;
        do_trig();
        step(TMO + 20);
        chk("noecho_nto", n_to - t0, 1);
        chk("noecho_nvalid", n_valid - v0, 0);
        chk("noecho_time", last_to_cyc - busy_rise_cyc, TMO);
        chk("noecho_dist", int'(bus.o_dist_cm), 100);
        chk("noecho_busy", int'(bus.o_busy), 0);

        measure("m57", 57, 0);

        // echo stuck high past the limit: timeout, then busy until echo drops
        v0 = n_valid; t0 = n_to;
        do_trig();
        step(100);
        bus.i_echo = 1'b1;
        f0 = cyc;
        step(TMO + 10);
        chk("stuck_nto", n_to - t0, 1);
        chk("stuck_time", last_to_cyc - f0, TMO + 4);
        chk("stuck_busy_hi", int'(bus.o_busy), 1);
        step(10000 - (TMO + 10));
        bus.i_echo = 1'b0;
        step(6);
        chk("stuck_busy_lo", int'(bus.o_busy), 0);
        chk("stuck_nvalid", n_valid - v0, 0);

        measure("m870", 870, 15);

        // reset in the middle of a measurement
        do_trig();
        step(50);
        bus.i_echo = 1'b1;
        step(100);
        rst = 1'b0;
        bus.i_echo = 1'b0;
        step(3);
        chk("midrst_dist", int'(bus.o_dist_cm), 0);
        chk("midrst_busy", int'(bus.o_busy), 0);
        chk("midrst_strobes", int'(bus.o_dist_valid) + int'(bus.o_timeout), 0);
        rst = 1'b1;
        step(5);
        chk("postrst_busy", int'(bus.o_busy), 0);
        measure("m1160", 1160, 20);

        // second trigger during MEASURE is dropped; a lone echo in IDLE is ignored
        v0 = n_valid; t0 = n_to;
        do_trig();
        step(50);
        bus.i_echo = 1'b1;
        step(100);
        do_trig();
        step(180);
        bus.i_echo = 1'b0;
        f0 = cyc;
        step(40);
        chk("retrig_nvalid", n_valid - v0, 1);
        chk("retrig_dist", int'(bus.o_dist_cm), 5);
        chk("retrig_latency", last_valid_cyc - f0, LAT_VALID);
        chk("retrig_busy", int'(bus.o_busy), 0);
        step(20);
        bus.i_echo = 1'b1;
        step(50);
        chk("idle_echo_busy", int'(bus.o_busy), 0);
        step(50);
        bus.i_echo = 1'b0;
        step(40);
        chk("idle_echo_nvalid", n_valid - v0, 1);
        chk("idle_echo_nto", n_to - t0, 0);
        chk("idle_echo_dist", int'(bus.o_dist_cm), 5);

        chk("strobe_overlap", overlap, 0);
        chk("strobe_len", long_strobe, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
